// File: rtl/tristate_demux_writer.sv
// rtl/tristate_demux_writer.sv - handshaked writer driving one slice of a shared tristate bus
module tristate_demux_writer #(
    parameter int W      = 8,
    parameter int DEST_W = 1,
    parameter int HOLD   = 2
) (
    input  logic                        clock,
    input  logic                        reset_,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                in_data,
    input  logic [DEST_W-1:0]           in_dest,
    inout  wire  [(2**DEST_W)*W-1:0]    bus,
    output logic [(2**DEST_W)-1:0]      strobe,
    output logic                        done,
    output logic                        err,
    input  logic                        err_clr
);

    localparam int N = 2**DEST_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic [W-1:0]       data_q;
    logic [DEST_W-1:0]  dest_q;
    logic [N-1:0]       en_q;
    logic [7:0]         hold_cnt;
    logic               mismatch;

    // Enables are flops cleared by the async reset, so the bus floats the moment reset_ falls.
    for (genvar i = 0; i < N; i++) begin : g_slice
        assign bus[i*W +: W] = en_q[i] ? data_q : {W{1'bz}};
    end

    assign strobe = en_q;

    // Case inequality so a contended (X) or floating (Z) slice is flagged.
    assign mismatch = (state == DRIVE) && (bus[dest_q*W +: W] !== data_q);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            data_q   <= '0;
            dest_q   <= '0;
            en_q     <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mismatch) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= in_data;
                        dest_q   <= in_dest;
                        in_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    en_q     <= {{(N-1){1'b0}}, 1'b1} << dest_q;
                    hold_cnt <= 8'(HOLD - 1);
                    state    <= DRIVE;
                end
                DRIVE: begin
                    if (hold_cnt == 8'd0) begin
                        en_q  <= '0;
                        done  <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                RELEASE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    en_q     <= '0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_demux_writer.sv
// tb/tb_tristate_demux_writer.sv - scoreboard bench for tristate_demux_writer
module tb_tristate_demux_writer;

    localparam int W      = 8;
    localparam int DEST_W = 1;
    localparam int N      = 2;
    localparam int HOLD   = 2;

    logic              clock   = 1'b0;
    logic              reset_  = 1'b0;
    logic              in_valid = 1'b0;
    logic              err_clr = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              in_ready;
    logic              done;
    logic              err;
    logic [N-1:0]      strobe;
    wire  [N*W-1:0]    bus;

    logic              tb_en  = 1'b0;
    logic [W-1:0]      tb_val = '0;

    assign bus[W-1:0] = tb_en ? tb_val : {W{1'bz}};

    tristate_demux_writer #(.W(W), .DEST_W(DEST_W), .HOLD(HOLD)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .bus      (bus),
        .strobe   (strobe),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DEST_W-1:0] dest;
        logic [W-1:0]      data;
        bit                chk_data;
    } drv_t;

    drv_t drv_q[$];
    int   done_q[$];
    int   acc_cyc[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    drv_t mon_e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zchk(string name, bit is_z, logic [31:0] act);
        checks++;
        if (!is_z) begin
            errors++;
            $display("FAIL %s: got %h expected all Z", name, act);
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        if (reset_ && in_valid && in_ready) acc_cyc.push_back(cyc);
    end

    // Monitor: pops one expected drive beat per strobed cycle and one entry per done pulse.
    always @(negedge clock) begin
        if (reset_) begin
            if (strobe !== '0) begin
                if (drv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got %b expected none", strobe);
                end else begin
                    mon_e = drv_q.pop_front();
                    chk("drive_strobe", 32'(strobe), 32'(2'b01 << mon_e.dest));
                    if (mon_e.dest == 1'b1) begin
                        if (mon_e.chk_data) chk("drive_data_s1", 32'(bus[15:8]), 32'(mon_e.data));
                        zchk("other_slice_z_s0", bus[7:0] === 8'bzzzzzzzz, 32'(bus[7:0]));
                    end else begin
                        if (mon_e.chk_data) chk("drive_data_s0", 32'(bus[7:0]), 32'(mon_e.data));
                        zchk("other_slice_z_s1", bus[15:8] === 8'bzzzzzzzz, 32'(bus[15:8]));
                    end
                end
            end else if (!tb_en) begin
                zchk("bus_z_without_strobe", bus === 16'bzzzzzzzzzzzzzzzz, 32'(bus));
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    void'(done_q.pop_front());
                    chk("done_strobe_clear", 32'(strobe), 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [DEST_W-1:0] dst,
                        input bit keep, input bit push, input bit chk_data);
        int n;
        in_data  = d;
        in_dest  = dst;
        in_valid = 1'b1;
        if (push) begin
            for (int k = 0; k < HOLD; k++) drv_q.push_back('{dst, d, chk_data});
            done_q.push_back(int'(dst));
        end
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clock);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] t2_strobe [1:5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    logic       t2_done   [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t2_rdy    [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int n0;
        int d0;

        // Reset with a pending request.
        reset_   = 1'b0;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        zchk("rst_bus_z", bus === 16'bzzzzzzzzzzzzzzzz, 32'(bus));
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_ = 1'b1;
        idle_wait(2);
        chk("rst_no_accept", 32'(acc_cyc.size()), 32'd0);
        chk("post_rst_strobe", 32'(strobe), 32'd0);

        // Single write, cycle-by-cycle timing.
        send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            chk($sformatf("t2_strobe_c%0d", c), 32'(strobe), 32'(t2_strobe[c]));
            chk($sformatf("t2_done_c%0d", c), 32'(done), 32'(t2_done[c]));
            chk($sformatf("t2_ready_c%0d", c), 32'(in_ready), 32'(t2_rdy[c]));
            if (c == 2 || c == 3) begin
                chk($sformatf("t2_hi_c%0d", c), 32'(bus[15:8]), 32'h0000_00A5);
                zchk($sformatf("t2_lo_z_c%0d", c), bus[7:0] === 8'bzzzzzzzz, 32'(bus[7:0]));
            end else begin
                zchk($sformatf("t2_bus_z_c%0d", c), bus === 16'bzzzzzzzzzzzzzzzz, 32'(bus));
            end
        end
        chk("t2_err", 32'(err), 32'd0);

        // Back-to-back with in_valid held high.
        n0 = acc_cyc.size();
        send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
        send(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b2b_accept_gap", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'(HOLD + 3));
        idle_wait(8);

        // Input changes and a stray valid during DRIVE must be ignored.
        n0 = acc_cyc.size();
        d0 = done_cnt;
        send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        idle_wait(6);
        chk("t4_single_accept", 32'(acc_cyc.size()), 32'(n0 + 1));
        chk("t4_single_done", 32'(done_cnt), 32'(d0 + 1));

        // Contention on slice 0 sets the sticky error.
        send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        tb_val = 8'hF0;
        tb_en  = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_err_set", 32'(err), 32'd1);
        @(posedge clock);
        #1;
        tb_en = 1'b0;
        idle_wait(4);
        chk("t5_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        err_clr = 1'b0;
        chk("t5_err_cleared", 32'(err), 32'd0);

        // Clear and mismatch on the same edge: set wins.
        send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        tb_en   = 1'b1;
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        tb_en   = 1'b0;
        err_clr = 1'b0;
        chk("t5_set_wins", 32'(err), 32'd1);
        idle_wait(3);
        chk("t5_set_wins_hold", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(posedge clock);
        #1;
        err_clr = 1'b0;
        chk("t5_err_recleared", 32'(err), 32'd0);

        // Reset during the first DRIVE cycle.
        d0 = done_cnt;
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #3;
        reset_ = 1'b0;
        #1;
        chk("t6_strobe_async", 32'(strobe), 32'd0);
        zchk("t6_bus_z_async", bus === 16'bzzzzzzzzzzzzzzzz, 32'(bus));
        chk("t6_done_async", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        chk("t6_ready_in_reset", 32'(in_ready), 32'd1);
        @(posedge clock);
        #2;
        reset_ = 1'b1;
        @(negedge clock);
        chk("t6_ready_after", 32'(in_ready), 32'd1);
        send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_wait(6);
        chk("t6_done_count", 32'(done_cnt), 32'(d0 + 1));

        chk("drive_queue_empty", 32'(drv_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
